// File: rtl/mp_seq_pkg.sv
// Shared types and program-word layout for the microprocessor sequencer.
// Program word: {ctrl[1:0], write_sel[1:0], read_sel2[1:0], read_sel1[1:0], instruction[3:0]}.
package mp_seq_pkg;

    localparam int PROG_W   = 12;
    localparam int INSN_LSB = 0;
    localparam int RS1_LSB  = 4;
    localparam int RS2_LSB  = 6;
    localparam int WS_LSB   = 8;
    localparam int CTRL_LSB = 10;

    typedef enum logic [1:0] {
        CTRL_EXEC = 2'b00,
        CTRL_BRZ  = 2'b01,
        CTRL_BRC  = 2'b10,
        CTRL_HALT = 2'b11
    } ctrl_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_SETTLE,
        S_DONE
    } seq_state_t;

    function automatic ctrl_t word_ctrl(input logic [PROG_W-1:0] w);
        return ctrl_t'(w[CTRL_LSB +: 2]);
    endfunction

endpackage

// File: rtl/mp_seq_prog_mem.sv
// Program store: synchronous write, registered read, deliberately not reset so
// a loaded program survives reset_n.
module mp_seq_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/microprocessor_sequencer.sv
// Stored-program sequencer driving the microprocessor core's instruction port.
// Optional watchdog step limit enabled with `define SEQ_WATCHDOG_EN.
module microprocessor_sequencer
    import mp_seq_pkg::*;
#(
    parameter int          PROG_DEPTH = 16,
    parameter int          AW         = $clog2(PROG_DEPTH),
    parameter int unsigned MAX_STEPS  = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [PROG_W-1:0] load_data,
    input  logic              start,
    input  logic [3:0]        result,
    input  logic              zero_flag,
    input  logic              carry_flag,
    output logic [3:0]        instruction,
    output logic [1:0]        read_sel1,
    output logic [1:0]        read_sel2,
    output logic [1:0]        write_sel,
    output logic              issue_valid,
    output logic [3:0]        last_result,
    output logic              last_zero,
    output logic              last_carry,
    output logic [AW-1:0]     pc,
    output logic              busy,
    output logic              done,
    output logic              error
);

    seq_state_t        state;
    logic [PROG_W-1:0] ir;
    logic              idle_or_done;
    logic              mem_we;
    logic              mem_re;
    ctrl_t             ctrl;
    logic [AW-1:0]     target;
    logic [AW-1:0]     pc_inc;
    logic              abort;

    assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
    assign mem_we       = load_en && idle_or_done;
    assign mem_re       = (state == S_FETCH);
    assign ctrl         = word_ctrl(ir);
    assign target       = ir[AW-1:0];
    assign pc_inc       = pc + 1'b1;

    mp_seq_prog_mem #(
        .DEPTH (PROG_DEPTH),
        .AW    (AW),
        .WIDTH (PROG_W)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (mem_re),
        .raddr (pc),
        .rdata (ir)
    );

`ifdef SEQ_WATCHDOG_EN
    logic [7:0] steps;
    logic [8:0] steps_inc;

    assign steps_inc = {1'b0, steps} + 9'd1;
    // The DECODE that brings the count to MAX_STEPS aborts unless it is a HALT.
    assign abort = (state == S_DECODE) && (steps_inc >= 9'(MAX_STEPS)) && (ctrl != CTRL_HALT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            steps <= '0;
            error <= 1'b0;
        end else if (idle_or_done && start) begin
            steps <= '0;
            error <= 1'b0;
        end else if (state == S_DECODE) begin
            steps <= steps_inc[7:0];
            if (abort) begin
                error <= 1'b1;
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^MAX_STEPS;
    assign abort      = 1'b0;
    assign error      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            pc          <= '0;
            instruction <= '0;
            read_sel1   <= '0;
            read_sel2   <= '0;
            write_sel   <= '0;
            issue_valid <= 1'b0;
            last_result <= '0;
            last_zero   <= 1'b0;
            last_carry  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            issue_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pc          <= '0;
                        last_result <= '0;
                        last_zero   <= 1'b0;
                        last_carry  <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        state       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        case (ctrl)
                            CTRL_EXEC: begin
                                instruction <= ir[INSN_LSB +: 4];
                                read_sel1   <= ir[RS1_LSB +: 2];
                                read_sel2   <= ir[RS2_LSB +: 2];
                                write_sel   <= ir[WS_LSB +: 2];
                                issue_valid <= 1'b1;
                                state       <= S_ISSUE;
                            end
                            CTRL_BRZ: begin
                                pc    <= last_zero ? target : pc_inc;
                                state <= S_FETCH;
                            end
                            CTRL_BRC: begin
                                pc    <= last_carry ? target : pc_inc;
                                state <= S_FETCH;
                            end
                            default: begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end
                        endcase
                    end
                end
                S_ISSUE: begin
                    state <= S_SETTLE;
                end
                S_SETTLE: begin
                    last_result <= result;
                    last_zero   <= zero_flag;
                    last_carry  <= carry_flag;
                    pc          <= pc_inc;
                    state       <= S_FETCH;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microprocessor_sequencer.sv
// Self-checking bench for microprocessor_sequencer against an instruction-level program model.
// Honours `define SEQ_WATCHDOG_EN (runs with MAX_STEPS=4 in that build).
module tb_microprocessor_sequencer;

    localparam int DEPTH = 16;
`ifdef SEQ_WATCHDOG_EN
    localparam int MAXS = 4;
    localparam bit WD   = 1'b1;
`else
    localparam int MAXS = 255;
    localparam bit WD   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [11:0] load_data;
    logic        start;
    logic [3:0]  result;
    logic        zero_flag;
    logic        carry_flag;
    logic [3:0]  instruction;
    logic [1:0]  read_sel1;
    logic [1:0]  read_sel2;
    logic [1:0]  write_sel;
    logic        issue_valid;
    logic [3:0]  last_result;
    logic        last_zero;
    logic        last_carry;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic        error;

    int tests = 0;
    int fails = 0;

    logic [3:0]  key;
    logic [4:0]  stub_sum;
    logic [11:0] exp_mem [DEPTH];

    int          exp_cycles;
    logic [3:0]  exp_pc;
    logic [3:0]  exp_lr;
    logic        exp_lz;
    logic        exp_lc;
    logic        exp_err;
    logic [9:0]  exp_issue_q [$];
    logic [3:0]  exp_fpc_q [$];
    int          exp_fcyc_q [$];

    microprocessor_sequencer #(
        .PROG_DEPTH (DEPTH),
        .MAX_STEPS  (MAXS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .result      (result),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .instruction (instruction),
        .read_sel1   (read_sel1),
        .read_sel2   (read_sel2),
        .write_sel   (write_sel),
        .issue_valid (issue_valid),
        .last_result (last_result),
        .last_zero   (last_zero),
        .last_carry  (last_carry),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    // Core stub: a 4-bit adder of instruction, {read_sel1,read_sel2} and a per-test key.
    function automatic logic [4:0] core_sum(input logic [3:0] ins, input logic [1:0] r1,
                                            input logic [1:0] r2, input logic [3:0] k);
        return {1'b0, ins} + {1'b0, r1, r2} + {1'b0, k};
    endfunction

    assign stub_sum   = core_sum(instruction, read_sel1, read_sel2, key);
    assign result     = stub_sum[3:0];
    assign carry_flag = stub_sum[4];
    assign zero_flag  = (stub_sum[3:0] == 4'd0);

    // Instruction-level interpreter: per instruction, what is fetched, issued and how long it costs.
    task automatic model_run();
        int         p;
        int         cyc;
        int         steps;
        logic [11:0] w;
        logic [4:0]  s;
        p = 0; cyc = 0; steps = 0;
        exp_lr = '0; exp_lz = 1'b0; exp_lc = 1'b0; exp_err = 1'b0;
        exp_issue_q.delete(); exp_fpc_q.delete(); exp_fcyc_q.delete();
        for (int k = 0; k < 1000; k++) begin
            exp_fpc_q.push_back(p[3:0]);
            exp_fcyc_q.push_back(cyc);
            w = exp_mem[p];
            steps++;
            if (WD && steps >= MAXS && w[11:10] != 2'b11) begin
                exp_err = 1'b1;
                cyc += 2;
                break;
            end
            if (w[11:10] == 2'b00) begin
                exp_issue_q.push_back(w[9:0]);
                s = core_sum(w[3:0], w[5:4], w[7:6], key);
                exp_lr = s[3:0]; exp_lc = s[4]; exp_lz = (s[3:0] == 4'd0);
                p = (p + 1) % DEPTH;
                cyc += 4;
            end else if (w[11:10] == 2'b01) begin
                p = exp_lz ? int'(w[3:0]) : (p + 1) % DEPTH;
                cyc += 2;
            end else if (w[11:10] == 2'b10) begin
                p = exp_lc ? int'(w[3:0]) : (p + 1) % DEPTH;
                cyc += 2;
            end else begin
                cyc += 2;
                break;
            end
        end
        exp_cycles = cyc;
        exp_pc     = p[3:0];
    endtask

    task automatic load_word(input int a, input logic [11:0] w);
        load_en   = 1'b1;
        load_addr = a[3:0];
        load_data = w;
        @(posedge clk); #1;
        load_en   = 1'b0;
        exp_mem[a] = w;
    endtask

    // Starts the stored program and follows it cycle by cycle against the model.
    task automatic run_prog(input string name, input bit busy_load, input bit load_with_start,
                            input logic [11:0] ls_word);
        int n;
        int fi;
        int iss;
        logic [9:0] got;
        if (load_with_start) exp_mem[0] = ls_word;
        model_run();
        start = 1'b1;
        if (load_with_start) begin
            load_en = 1'b1; load_addr = 4'd0; load_data = ls_word;
        end
        @(posedge clk); #1;
        start = 1'b0; load_en = 1'b0;
        n = 0; fi = 0; iss = 0;
        for (int g = 0; g < 600; g++) begin
            if (fi < exp_fpc_q.size() && exp_fcyc_q[fi] == n) begin
                tests++;
                if (pc !== exp_fpc_q[fi]) begin
                    fails++;
                    $display("FAIL %s fetch_pc cycle=%0d got=%0h exp=%0h", name, n, pc, exp_fpc_q[fi]);
                end
                fi++;
            end
            if (issue_valid === 1'b1) begin
                got = {write_sel, read_sel2, read_sel1, instruction};
                tests++;
                if (iss >= exp_issue_q.size()) begin
                    fails++;
                    $display("FAIL %s extra_issue cycle=%0d got=%0h exp=none", name, n, got);
                end else if (got !== exp_issue_q[iss]) begin
                    fails++;
                    $display("FAIL %s issue_fields cycle=%0d got=%0h exp=%0h", name, n, got, exp_issue_q[iss]);
                end
                iss++;
            end
            if (busy_load && n == 1) begin
                load_en = 1'b1; load_addr = 4'd0; load_data = 12'hC00;
            end
            if (n == 2) load_en = 1'b0;
            if (done === 1'b1) break;
            @(posedge clk); #1;
            n++;
        end
        load_en = 1'b0;
        tests++;
        if (done !== 1'b1 || n != exp_cycles) begin
            fails++;
            $display("FAIL %s done_timing done=%b cycles=%0d exp_cycles=%0d", name, done, n, exp_cycles);
        end
        tests++;
        if (pc !== exp_pc) begin
            fails++;
            $display("FAIL %s final_pc got=%0h exp=%0h", name, pc, exp_pc);
        end
        tests++;
        if ({last_result, last_zero, last_carry} !== {exp_lr, exp_lz, exp_lc}) begin
            fails++;
            $display("FAIL %s last_flags got=%0h/%b/%b exp=%0h/%b/%b", name,
                     last_result, last_zero, last_carry, exp_lr, exp_lz, exp_lc);
        end
        tests++;
        if (error !== exp_err || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s error_busy got=%b/%b exp=%b/0", name, error, busy, exp_err);
        end
        tests++;
        if (iss != exp_issue_q.size()) begin
            fails++;
            $display("FAIL %s issue_count got=%0d exp=%0d", name, iss, exp_issue_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0; key = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({instruction, read_sel1, read_sel2, write_sel} !== 10'd0) begin
            fails++;
            $display("FAIL reset_core_outputs got=%0h exp=0", {instruction, read_sel1, read_sel2, write_sel});
        end
        tests++;
        if ({issue_valid, busy, done, error} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_status got=%b exp=0000", {issue_valid, busy, done, error});
        end
        tests++;
        if ({pc, last_result, last_zero, last_carry} !== 10'd0) begin
            fails++;
            $display("FAIL reset_pc_last got=%0h exp=0", {pc, last_result, last_zero, last_carry});
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int a = 0; a < DEPTH; a++) load_word(a, 12'hC00);
    endtask

    task automatic test_basic();
        key = 4'd0;
        load_word(0, 12'h070);
        load_word(1, 12'hC00);
        run_prog("basic", 1'b0, 1'b0, 12'h000);
        tests++;
        if (pc !== 4'd1 || done !== 1'b1) begin
            fails++;
            $display("FAIL basic_halt_pc got=%0h/%b exp=1/1", pc, done);
        end
    endtask

    task automatic test_branch();
        load_word(0, 12'h000);
        load_word(1, 12'h405);
        load_word(2, 12'hC00);
        load_word(5, 12'hC00);
        key = 4'd0;
        run_prog("brz_taken", 1'b0, 1'b0, 12'h000);
        tests++;
        if (pc !== 4'd5) begin
            fails++;
            $display("FAIL brz_taken_pc got=%0h exp=5", pc);
        end
        key = 4'd3;
        run_prog("brz_not_taken", 1'b0, 1'b0, 12'h000);
        tests++;
        if (pc !== 4'd2) begin
            fails++;
            $display("FAIL brz_not_taken_pc got=%0h exp=2", pc);
        end
    endtask

    task automatic test_wrap();
        key = 4'd0;
        load_word(0, 12'h803);
        load_word(1, 12'h000);
        load_word(2, 12'h40F);
        load_word(3, 12'hC00);
        load_word(15, 12'h2FF);
        run_prog("pc_wrap", 1'b0, 1'b0, 12'h000);
    endtask

    task automatic test_load_busy();
        key = 4'd0;
        load_word(0, 12'h070);
        load_word(1, 12'hC00);
        run_prog("load_while_busy", 1'b1, 1'b0, 12'h000);
        run_prog("after_dropped_load", 1'b0, 1'b0, 12'h000);
    endtask

    task automatic test_load_with_start();
        key = 4'd0;
        load_word(0, 12'h070);
        run_prog("load_with_start", 1'b0, 1'b1, 12'hC07);
        tests++;
        if (pc !== 4'd0) begin
            fails++;
            $display("FAIL load_with_start_pc got=%0h exp=0", pc);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        key = 4'd0;
        load_word(0, 12'h070);
        load_word(1, 12'hC00);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (issue_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (n != 2) begin
            fails++;
            $display("FAIL issue_latency got=%0d exp=2", n);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if ({issue_valid, busy, done, pc} !== 7'd0 || instruction !== 4'd0 || read_sel1 !== 2'd0) begin
            fails++;
            $display("FAIL async_reset got=%b/%b/%b/%0h/%0h exp=0/0/0/0/0",
                     issue_valid, busy, done, pc, instruction);
        end
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_prog("rerun_after_reset", 1'b0, 1'b0, 12'h000);
    endtask

    task automatic test_random();
        logic [11:0] w;
        int c;
        for (int r = 0; r < 6; r++) begin
            key = 4'($urandom);
            for (int a = 0; a < DEPTH; a++) begin
                c = int'($urandom_range(7, 0));
                if (a == DEPTH - 1 || c == 7)
                    w = {2'b11, 10'($urandom)};
                else if (c < 4)
                    w = {2'b00, 10'($urandom)};
                else
                    w = {(c == 6) ? 2'b10 : 2'b01, 6'($urandom),
                         4'($urandom_range(DEPTH - 1, a + 1))};
                load_word(a, w);
            end
            run_prog($sformatf("random%0d", r), 1'b0, 1'b0, 12'h000);
        end
    endtask

    task automatic test_watchdog();
        key = 4'd0;
        load_word(0, 12'h000);
        load_word(1, 12'h400);
        run_prog("watchdog_loop", 1'b0, 1'b0, 12'h000);
        tests++;
        if (error !== 1'b1 || done !== 1'b1) begin
            fails++;
            $display("FAIL watchdog_abort got=%b/%b exp=1/1", error, done);
        end
        load_word(0, 12'hC00);
        run_prog("watchdog_clear", 1'b0, 1'b0, 12'h000);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_wrap();
        test_load_busy();
        test_load_with_start();
        test_reset_mid_run();
        test_random();
`ifdef SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
